// File: rtl/sd_bus_sched.sv
// sd_bus_sched: bus owner and request scheduler for the SD SPI port.
// The init engine owns the pins until init_o rises. After that, host read and
// write requests are granted one at a time. Each grant sends a one-cycle start
// pulse to its engine and muxes that engine's MOSI/CSn onto the card pins until
// the engine reports done or the watchdog expires. A forced CS-high gap
// separates consecutive transactions.
//
// Ports:
//   SD_CK                  clock; all state changes on its falling edge
//   rst_n                  asynchronous active-low reset
//   init_o                 init engine finished, card ready
//   wr_req / rd_req        host requests (level, held until the matching ack)
//   wr_ack / rd_ack        one-cycle completion pulses to the host
//   write_seq / read_seq   one-cycle start pulses to the engines
//   wr_done / rd_done      one-cycle completion pulses from the engines
//   init_/wr_/rd_MOSI,CSn  engine pin requests
//   SD_MOSI / SD_CSn       card pins
//   owner                  0=init 1=write 2=read 3=none
//   busy                   high while a transaction is in START/BUSY/DONE
//   err                    watchdog expired on the last transaction (sticky)
module sd_bus_sched #(
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 8
) (
    input  logic       SD_CK,
    input  logic       rst_n,
    input  logic       init_o,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic       wr_ack,
    output logic       rd_ack,
    output logic       write_seq,
    output logic       read_seq,
    input  logic       wr_done,
    input  logic       rd_done,
    input  logic       init_MOSI,
    input  logic       init_CSn,
    input  logic       wr_MOSI,
    input  logic       wr_CSn,
    input  logic       rd_MOSI,
    input  logic       rd_CSn,
    output logic       SD_MOSI,
    output logic       SD_CSn,
    output logic [1:0] owner,
    output logic       busy,
    output logic       err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] G_INIT = GW'(GAP);
    localparam logic [GW-1:0] G_LOAD = GW'(GAP - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_START, S_BUSY, S_DONE, S_GAP
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;      // watchdog, loaded on grant, runs through START and BUSY
    logic [GW-1:0] gcnt;      // CS-high gap length
    logic          rr_rd;     // tie-break pointer: 1 = read wins the next tie
    logic          grant_rd;  // engine owning the current transaction
    logic          pick_rd;
    logic          grant_done;

    assign pick_rd    = rd_req && (!wr_req || rr_rd);
    // Only the granted engine can end a transaction.
    assign grant_done = grant_rd ? rd_done : wr_done;

    always_ff @(negedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            owner     <= 2'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            write_seq <= 1'b0;
            read_seq  <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rr_rd     <= 1'b1;
            grant_rd  <= 1'b0;
            tcnt      <= '0;
            gcnt      <= '0;
        end else begin
            write_seq <= 1'b0;
            read_seq  <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            if (tcnt != '0) tcnt <= tcnt - 1'b1;
            if (gcnt != '0) gcnt <= gcnt - 1'b1;
            case (state)
                S_INIT: begin
                    owner <= 2'd0;
                    if (init_o) begin
                        state <= S_GAP;
                        owner <= 2'd3;
                        gcnt  <= G_INIT;
                    end
                end
                S_IDLE: begin
                    owner <= 2'd3;
                    if (!init_o) begin
                        state <= S_INIT;
                        owner <= 2'd0;
                    end else if (wr_req || rd_req) begin
                        state     <= S_START;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        tcnt      <= T_LOAD;
                        grant_rd  <= pick_rd;
                        owner     <= pick_rd ? 2'd2 : 2'd1;
                        read_seq  <= pick_rd;
                        write_seq <= !pick_rd;
                        if (wr_req && rd_req) rr_rd <= !pick_rd;
                    end
                end
                S_START: state <= S_BUSY;
                S_BUSY: begin
                    // done beats a simultaneous watchdog expiry
                    if (grant_done || tcnt == '0) begin
                        state  <= S_DONE;
                        owner  <= 2'd3;
                        err    <= !grant_done;
                        wr_ack <= !grant_rd;
                        rd_ack <= grant_rd;
                    end
                end
                S_DONE: begin
                    state <= S_GAP;
                    busy  <= 1'b0;
                    gcnt  <= G_LOAD;
                end
                S_GAP: begin
                    if (gcnt == '0) state <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Pin mux follows the registered owner; an unowned bus idles high.
    always_comb begin
        SD_MOSI = 1'b1;
        SD_CSn  = 1'b1;
        case (owner)
            2'd0: begin SD_MOSI = init_MOSI; SD_CSn = init_CSn; end
            2'd1: begin SD_MOSI = wr_MOSI;   SD_CSn = wr_CSn;   end
            2'd2: begin SD_MOSI = rd_MOSI;   SD_CSn = rd_CSn;   end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sd_bus_sched.sv
`timescale 1ns/1ps
module tb_sd_bus_sched;
    logic clk = 1'b1;
    logic rst_n, init_o, wr_req, rd_req, wr_done, rd_done;
    logic init_MOSI, init_CSn, wr_MOSI, wr_CSn, rd_MOSI, rd_CSn;
    logic sel;  // 0: default-parameter DUT, 1: short-watchdog DUT

    logic a_wr_ack, a_rd_ack, a_write_seq, a_read_seq, a_SD_MOSI, a_SD_CSn, a_busy, a_err;
    logic b_wr_ack, b_rd_ack, b_write_seq, b_read_seq, b_SD_MOSI, b_SD_CSn, b_busy, b_err;
    logic [1:0] a_owner, b_owner;

    logic o_wr_ack, o_rd_ack, o_write_seq, o_read_seq, o_SD_MOSI, o_SD_CSn, o_busy, o_err;
    logic [1:0] o_owner;

    always #10 clk = ~clk;

    sd_bus_sched dut_a (
        .SD_CK(clk), .rst_n(rst_n), .init_o(init_o), .wr_req(wr_req), .rd_req(rd_req),
        .wr_ack(a_wr_ack), .rd_ack(a_rd_ack), .write_seq(a_write_seq), .read_seq(a_read_seq),
        .wr_done(wr_done), .rd_done(rd_done),
        .init_MOSI(init_MOSI), .init_CSn(init_CSn), .wr_MOSI(wr_MOSI), .wr_CSn(wr_CSn),
        .rd_MOSI(rd_MOSI), .rd_CSn(rd_CSn), .SD_MOSI(a_SD_MOSI), .SD_CSn(a_SD_CSn),
        .owner(a_owner), .busy(a_busy), .err(a_err)
    );

    sd_bus_sched #(.TIMEOUT(16), .GAP(8)) dut_b (
        .SD_CK(clk), .rst_n(rst_n), .init_o(init_o), .wr_req(wr_req), .rd_req(rd_req),
        .wr_ack(b_wr_ack), .rd_ack(b_rd_ack), .write_seq(b_write_seq), .read_seq(b_read_seq),
        .wr_done(wr_done), .rd_done(rd_done),
        .init_MOSI(init_MOSI), .init_CSn(init_CSn), .wr_MOSI(wr_MOSI), .wr_CSn(wr_CSn),
        .rd_MOSI(rd_MOSI), .rd_CSn(rd_CSn), .SD_MOSI(b_SD_MOSI), .SD_CSn(b_SD_CSn),
        .owner(b_owner), .busy(b_busy), .err(b_err)
    );

    assign o_wr_ack    = sel ? b_wr_ack    : a_wr_ack;
    assign o_rd_ack    = sel ? b_rd_ack    : a_rd_ack;
    assign o_write_seq = sel ? b_write_seq : a_write_seq;
    assign o_read_seq  = sel ? b_read_seq  : a_read_seq;
    assign o_SD_MOSI   = sel ? b_SD_MOSI   : a_SD_MOSI;
    assign o_SD_CSn    = sel ? b_SD_CSn    : a_SD_CSn;
    assign o_owner     = sel ? b_owner     : a_owner;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_err       = sel ? b_err       : a_err;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // pins = {init_MOSI, init_CSn, wr_MOSI, wr_CSn, rd_MOSI, rd_CSn}, exp = {SD_MOSI, SD_CSn}
    typedef struct { logic [1:0] own; logic [5:0] pins; logic [1:0] exp; } pin_vec_t;
    pin_vec_t pv[14];

    typedef struct { bit rd; bit err; } exp_ack_t;
    exp_ack_t sb[$];
    exp_ack_t e;

    // Scoreboard: every ack from the selected DUT must match the oldest expectation.
    always @(posedge clk) begin
        if (o_wr_ack || o_rd_ack) begin
            check("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_ack_rd", o_rd_ack, e.rd);
                check("sb_ack_wr", o_wr_ack, !e.rd);
                check("sb_ack_err", o_err, e.err);
            end
        end
    end

    function automatic logic seq_of(input bit rd);
        return rd ? o_read_seq : o_write_seq;
    endfunction

    task automatic apply_pins(input logic [1:0] own);
        for (int i = 0; i < 14; i++) begin
            if (pv[i].own == own) begin
                {init_MOSI, init_CSn, wr_MOSI, wr_CSn, rd_MOSI, rd_CSn} = pv[i].pins;
                #1;
                check($sformatf("pinmux_%0d", i), {o_SD_MOSI, o_SD_CSn}, pv[i].exp);
            end
        end
        {init_MOSI, init_CSn, wr_MOSI, wr_CSn, rd_MOSI, rd_CSn} = '0;
    endtask

    // Caller raises the request; this follows the transaction through its gap.
    // k counts rising edges since the one that saw the start pulse.
    task automatic run_xact(input bit rd, input int done_at, input bit exp_err,
                            input int glitch_at, input int exp_k);
        int k;
        bit ok;
        logic [1:0] own;
        own = rd ? 2'd2 : 2'd1;
        k = 0;
        while (seq_of(rd) !== 1'b1 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check("start_seq", seq_of(rd), 1);
        check("start_other_seq", seq_of(!rd), 0);
        check("start_owner", o_owner, own);
        check("start_err_clear", o_err, 0);
        check("start_busy", o_busy, 1);
        @(posedge clk);
        check("seq_one_cycle", seq_of(rd), 0);
        apply_pins(own);
        ok = 1;
        k = 1;
        while (!(o_wr_ack || o_rd_ack) && k < 1000) begin
            if (o_owner != own) ok = 0;
            if (rd) begin rd_done = (k == done_at); wr_done = (k == glitch_at); end
            else    begin wr_done = (k == done_at); rd_done = (k == glitch_at); end
            @(posedge clk);
            k++;
        end
        wr_done = 0;
        rd_done = 0;
        check("owner_held_busy", ok, 1);
        check("ack_cycle", k, exp_k);
        check("ack_right_engine", rd ? o_rd_ack : o_wr_ack, 1);
        check("ack_err", o_err, exp_err);
        check("done_owner_none", o_owner, 3);
        if (rd) rd_req = 0; else wr_req = 0;
        @(posedge clk);
        check("ack_one_cycle", o_wr_ack | o_rd_ack, 0);
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            if (o_SD_CSn !== 1'b1 || o_SD_MOSI !== 1'b1 || o_owner != 2'd3) ok = 0;
            @(posedge clk);
        end
        check("gap_cs_high", ok, 1);
        check("gap_not_busy", o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit ok;
        pv[0]  = '{2'd0, 6'b001111, 2'b00};
        pv[1]  = '{2'd0, 6'b100000, 2'b10};
        pv[2]  = '{2'd0, 6'b011010, 2'b01};
        pv[3]  = '{2'd0, 6'b110000, 2'b11};
        pv[4]  = '{2'd1, 6'b110011, 2'b00};
        pv[5]  = '{2'd1, 6'b001000, 2'b10};
        pv[6]  = '{2'd1, 6'b110111, 2'b01};
        pv[7]  = '{2'd1, 6'b001100, 2'b11};
        pv[8]  = '{2'd2, 6'b111100, 2'b00};
        pv[9]  = '{2'd2, 6'b000010, 2'b10};
        pv[10] = '{2'd2, 6'b111101, 2'b01};
        pv[11] = '{2'd2, 6'b000011, 2'b11};
        pv[12] = '{2'd3, 6'b000000, 2'b11};
        pv[13] = '{2'd3, 6'b100110, 2'b11};

        sel = 0; rst_n = 0; init_o = 0; wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;
        {init_MOSI, init_CSn, wr_MOSI, wr_CSn, rd_MOSI, rd_CSn} = '0;
        repeat (3) @(posedge clk);

        // Reset state: init engine owns the pins.
        check("rst_owner", o_owner, 0);
        check("rst_pins", {o_SD_MOSI, o_SD_CSn}, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_pulses", {o_write_seq, o_read_seq, o_wr_ack, o_rd_ack}, 0);
        rst_n = 1;
        repeat (2) @(posedge clk);
        check("init_hold_owner", o_owner, 0);
        apply_pins(2'd0);

        // Init done: bus released with a CS-high gap.
        init_o = 1;
        @(posedge clk);
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            if (o_owner != 2'd3 || o_SD_CSn !== 1'b1 || o_SD_MOSI !== 1'b1) ok = 0;
            @(posedge clk);
        end
        check("init_gap", ok, 1);
        repeat (3) @(posedge clk);
        check("idle_busy", o_busy, 0);
        apply_pins(2'd3);

        // Single write, engine done 600 cycles after the start pulse.
        sb.push_back('{0, 0});
        wr_req = 1;
        run_xact(0, 600, 0, 0, 601);

        // Simultaneous requests: read first (reset pointer), then write.
        sb.push_back('{1, 0});
        sb.push_back('{0, 0});
        wr_req = 1;
        rd_req = 1;
        run_xact(1, 20, 0, 0, 21);
        run_xact(0, 10, 0, 0, 11);

        // Pointer now favours write.
        sb.push_back('{0, 0});
        sb.push_back('{1, 0});
        wr_req = 1;
        rd_req = 1;
        run_xact(0, 5, 0, 0, 6);
        run_xact(1, 7, 0, 0, 8);

        // Switch to the short-watchdog instance.
        rst_n = 0;
        @(posedge clk);
        sel = 1;
        @(posedge clk);
        rst_n = 1;
        repeat (12) @(posedge clk);

        // Read with no done: watchdog ends it 16 cycles after the start pulse.
        sb.push_back('{1, 1});
        rd_req = 1;
        run_xact(1, 0, 1, 0, 16);
        check("err_sticky_idle", o_err, 1);

        // Write: stray rd_done ignored; wr_done on the expiry edge wins.
        sb.push_back('{0, 0});
        wr_req = 1;
        run_xact(0, 15, 0, 5, 16);

        // Reset during BUSY.
        wr_req = 1;
        k = 0;
        while (o_write_seq !== 1'b1 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check("rst_test_seq", o_write_seq, 1);
        repeat (3) @(posedge clk);
        check("rst_test_in_busy", o_owner, 1);
        rst_n = 0;
        #1;
        check("midrst_owner", o_owner, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_pins", {o_SD_MOSI, o_SD_CSn}, 0);
        check("midrst_pulses", {o_write_seq, o_read_seq, o_wr_ack, o_rd_ack}, 0);
        wr_req = 0;
        repeat (2) @(posedge clk);
        rst_n = 1;
        ok = 1;
        for (int i = 0; i < 30; i++) begin
            if (o_write_seq || o_read_seq || o_wr_ack || o_rd_ack) ok = 0;
            @(posedge clk);
        end
        check("post_rst_quiet", ok, 1);
        check("post_rst_owner", o_owner, 3);

        // Normal flow resumes.
        sb.push_back('{1, 0});
        rd_req = 1;
        run_xact(1, 8, 0, 0, 9);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sd_bus_sched.md
# sd_bus_sched

Scheduler and bus owner for the SD SPI port. Holds the bus for the init engine until `init_o`, then serves read and write requests from the host side. Each request gets a start pulse to the matching engine (`write_seq` / `read_seq`), and the block multiplexes that engine's MOSI/CSn onto the pins until the engine reports done. It adds a timeout watchdog and a guaranteed CS-high idle gap between transactions.

## Interface
- `TIMEOUT`, 4096: max SD_CK cycles from start pulse to engine done before abort.
- `GAP`, 8: SD_CK cycles with CSn=1, MOSI=1 forced between transactions (≥1).
- `SD_CK` in 1: clock. All registers update on the falling edge, same as the engines.
- `rst_n` in 1: asynchronous, active-low reset.
- `init_o` in 1: init engine finished, card ready.
- `wr_req` in 1: host write request, level, held until `wr_ack`.
- `rd_req` in 1: host read request, level, held until `rd_ack`.
- `wr_ack` out 1: one-cycle pulse at end of a write transaction.
- `rd_ack` out 1: one-cycle pulse at end of a read transaction.
- `write_seq` out 1: one-cycle start pulse to the write engine.
- `read_seq` out 1: one-cycle start pulse to the read engine.
- `wr_done` in 1: one-cycle completion pulse from the write engine.
- `rd_done` in 1: one-cycle completion pulse from the read engine.
- `init_MOSI`, `init_CSn` in 1 each: init engine pins.
- `wr_MOSI`, `wr_CSn` in 1 each: write engine pins.
- `rd_MOSI`, `rd_CSn` in 1 each: read engine pins.
- `SD_MOSI`, `SD_CSn` out 1 each: card pins.
- `owner` out 2: current bus owner. 0=init, 1=write, 2=read, 3=none.
- `busy` out 1: high in START, BUSY and DONE.
- `err` out 1: timeout flag. Sticky; cleared on the next START.

## Operation
- States: INIT, IDLE, START, BUSY, DONE, GAP.
- Reset values:
  - state=INIT, owner=0, err=0, busy=0.
  - All seq/ack outputs 0.
  - Round-robin pointer favours read.
  - Pins follow `init_MOSI`/`init_CSn`.
- Pin mux (combinational from registered `owner`):
  - owner 0 → init pins.
  - owner 1 → wr pins.
  - owner 2 → rd pins.
  - owner 3 → MOSI=1, CSn=1.
- INIT: owner=0. When `init_o`=1 → GAP, owner=3, gap counter loaded with GAP.
- IDLE: owner=3.
  - `init_o`=0 → INIT.
  - Else if exactly one request is pending → START for that requester.
  - Else if both are pending → the pointer picks the requester; the pointer then moves to favour the other.
  - Else stay in IDLE.
- START: one cycle. owner=granted engine; its seq=1; err cleared; timeout counter loaded with TIMEOUT-1 → BUSY.
- BUSY: counter decrements per cycle.
  - Granted engine's done=1 → DONE.
  - Else if counter==0 → DONE with err=1.
  - Done from the non-granted engine is ignored.
- DONE: one cycle. Matching ack=1; owner=3 → GAP, gap counter=GAP-1.
- GAP: owner=3. When counter==0 → IDLE.
- `init_o` is checked only in IDLE. A falling `init_o` mid-transaction takes effect after the GAP.
- Requests are sampled only in IDLE. A request dropped before grant is never served. No ack without a prior seq.
- Counter widths: $clog2(TIMEOUT), $clog2(GAP)+1. Decrement saturates at 0.

## Timing
- Grant latency: request high at IDLE edge n → START at n+1 (seq high for cycle n+1) → BUSY at n+2.
- Done sampled at edge m in BUSY → ack high for one cycle at m+1 → GAP for exactly GAP cycles → IDLE.
- Done and counter==0 on the same edge → done wins, err=0.
- Timeout: with no done, DONE is entered TIMEOUT cycles after START. err rises with ack and stays high until the next START.
- Back-to-back: minimum request-to-request spacing is 1+1+1+GAP cycles plus engine time. CSn is guaranteed high for ≥GAP cycles between engines.
- Reset asserted mid-transaction: immediate return to INIT, owner=0, no ack issued. The engine is reset by the same `rst_n`.

## Test plan
- Reset with `init_o`=0, drive `init_CSn`=0, `init_MOSI`=0 → SD_CSn=0, SD_MOSI=0, owner=0. Raise `init_o` → owner=3, pins 1/1 for 8 cycles, then IDLE.
- After init, `wr_req`=1; `wr_done` 600 cycles after `write_seq` → `write_seq` one cycle, owner=1 for the whole BUSY period, `wr_ack` one cycle, err=0, CSn=1 for 8 cycles afterwards.
- `wr_req` and `rd_req` both raised in the same cycle, held through two transactions → read served first (reset pointer), then write. Two acks, each followed by an 8-cycle gap.
- TIMEOUT=16, `rd_req` with no `rd_done` → `rd_ack` 16 cycles after `read_seq`, err=1. The next write START clears err.
- `rd_done` pulsed during a write transaction → ignored, no ack. `wr_done` on the same edge the counter hits 0 → `wr_ack`, err=0.
- `rst_n` pulsed low during BUSY → owner=0, no ack, no seq. `init_o`=1 afterwards restarts the normal flow.
